// File: rtl/lif_step_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one time step walks every
// virtual neuron through fetch/update and hands any spike to a ready/valid consumer.
module lif_step_scheduler #(
    parameter int N_NEURONS  = 4,
    parameter int THRESHOLD  = 100,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRACT    = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         step_start,
    input  logic [7:0]                   input_current,
    input  logic                         spike_ready,
    output logic [$clog2(N_NEURONS)-1:0] cur_idx,
    output logic                         step_busy,
    output logic                         spike_valid,
    output logic [$clog2(N_NEURONS)-1:0] spike_id,
    output logic                         step_done,
    output logic [15:0]                  spike_count
);

    localparam int IW = $clog2(N_NEURONS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_UPDATE = 3'd2,
        S_EMIT   = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      in_q, in_d;
    logic [7:0]      v_q [N_NEURONS];
    logic [7:0]      v_d [N_NEURONS];
    logic [3:0]      r_q [N_NEURONS];
    logic [3:0]      r_d [N_NEURONS];
    logic [15:0]     cnt_q, cnt_d;

    logic [7:0]      cur_v_s;
    logic [8:0]      sum_s;
    logic [7:0]      sat_s;

    // Next-state and datapath for the per-neuron update sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        in_d    = in_q;
        v_d     = v_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        cur_v_s = v_q[idx_q];
        // Leaked membrane never exceeds 255, so 9 bits hold leak + 8-bit input.
        sum_s   = {1'b0, cur_v_s} - {1'b0, (cur_v_s >> LEAK_SHIFT)} + {1'b0, in_q};
        sat_s   = sum_s[8] ? 8'hFF : sum_s[7:0];

        case (state_q)
            S_IDLE: begin
                if (step_start) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                in_d    = input_current;
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                if (r_q[idx_q] != 4'd0) begin
                    r_d[idx_q] = r_q[idx_q] - 4'd1;
                    v_d[idx_q] = 8'd0;
                    state_d    = S_NEXT;
                end else if (sat_s >= 8'(THRESHOLD)) begin
                    v_d[idx_q] = 8'd0;
                    r_d[idx_q] = 4'(REFRACT);
                    state_d    = S_EMIT;
                end else begin
                    v_d[idx_q] = sat_s;
                    state_d    = S_NEXT;
                end
            end
            S_EMIT: begin
                if (spike_ready) begin
                    cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    state_d = S_NEXT;
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_NEXT: begin
                if (idx_q == IW'(N_NEURONS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + {{(IW-1){1'b0}}, 1'b1};
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, neuron memories and spike counter; reset aborts any step in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            in_q    <= 8'd0;
            cnt_q   <= 16'd0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v_q[i] <= 8'd0;
                r_q[i] <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            in_q    <= in_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            r_q     <= r_d;
        end
    end

    // Outputs decode registered state only, so reset clears them at once.
    assign cur_idx     = idx_q;
    assign spike_id    = idx_q;
    assign step_busy   = (state_q != S_IDLE);
    assign spike_valid = (state_q == S_EMIT);
    assign step_done   = (state_q == S_DONE);
    assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Bench for lif_step_scheduler: directed table, randomized steps against an
// arithmetic neuron model, and reset-abort sequences on two threshold variants.
module tb_lif_step_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ss   [2];
    logic [7:0]  ic   [2];
    logic        sr   [2];
    logic [1:0]  cidx [2];
    logic        busy [2];
    logic        sv   [2];
    logic [1:0]  sid  [2];
    logic        sd   [2];
    logic [15:0] cnt  [2];

    lif_step_scheduler dut (
        .clk(clk), .reset(reset), .step_start(ss[0]), .input_current(ic[0]),
        .spike_ready(sr[0]), .cur_idx(cidx[0]), .step_busy(busy[0]),
        .spike_valid(sv[0]), .spike_id(sid[0]), .step_done(sd[0]),
        .spike_count(cnt[0]));

    lif_step_scheduler #(.THRESHOLD(255)) dut2 (
        .clk(clk), .reset(reset), .step_start(ss[1]), .input_current(ic[1]),
        .spike_ready(sr[1]), .cur_idx(cidx[1]), .step_busy(busy[1]),
        .spike_valid(sv[1]), .spike_id(sid[1]), .step_done(sd[1]),
        .spike_count(cnt[1]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: membranes, refractory counts, accepted spike totals.
    int mv [2][4];
    int mr [2][4];
    int mcnt [2];
    int exp_ids [$];

    function automatic int th(input int sel);
        return (sel == 0) ? 100 : 255;
    endfunction

    function automatic logic [3:0][7:0] mkcur(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic int get_v(input int sel, input int i);
        if (sel == 0) return int'(dut.v_q[i]);
        else          return int'(dut2.v_q[i]);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            mcnt[s] = 0;
            for (int i = 0; i < 4; i++) begin
                mv[s][i] = 0;
                mr[s][i] = 0;
            end
        end
    endtask

    task automatic model_step(input int sel, input logic [3:0][7:0] cur);
        int s;
        exp_ids.delete();
        for (int i = 0; i < 4; i++) begin
            if (mr[sel][i] > 0) begin
                mr[sel][i] = mr[sel][i] - 1;
                mv[sel][i] = 0;
            end else begin
                s = mv[sel][i] - mv[sel][i] / 8 + int'(cur[i]);
                if (s > 255) s = 255;
                if (s >= th(sel)) begin
                    mv[sel][i] = 0;
                    mr[sel][i] = 2;
                    exp_ids.push_back(i);
                end else begin
                    mv[sel][i] = s;
                end
            end
        end
        mcnt[sel] = mcnt[sel] + exp_ids.size();
        if (mcnt[sel] > 65535) mcnt[sel] = 65535;
    endtask

    task automatic check_zero(input int sel);
        check("rst_busy",  int'(busy[sel]), 0);
        check("rst_valid", int'(sv[sel]),   0);
        check("rst_done",  int'(sd[sel]),   0);
        check("rst_idx",   int'(cidx[sel]), 0);
        check("rst_id",    int'(sid[sel]),  0);
        check("rst_count", int'(cnt[sel]),  0);
    endtask

    // One full step: drives currents by cur_idx, throttles spike_ready, checks timing and state.
    task automatic run_step(input int sel, input logic [3:0][7:0] cur, input int lowc,
                            input bit poke, output int done_cyc, output logic [3:0] gmask);
        int got [$];
        int low_left;
        bit in_emit;
        bit stable_ok;
        logic [1:0] emit_id;
        int exp_done;
        model_step(sel, cur);
        done_cyc  = -1;
        gmask     = 4'b0000;
        low_left  = 0;
        in_emit   = 1'b0;
        stable_ok = 1'b1;
        emit_id   = 2'd0;
        @(negedge clk); ss[sel] = 1'b1;
        @(negedge clk); ss[sel] = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            ic[sel] = cur[cidx[sel]];
            ss[sel] = (poke && cyc == 5) ? 1'b1 : 1'b0;
            if (sv[sel]) begin
                if (!in_emit) begin
                    in_emit  = 1'b1;
                    emit_id  = sid[sel];
                    got.push_back(int'(sid[sel]));
                    gmask[sid[sel]] = 1'b1;
                    low_left = lowc;
                end else if (sid[sel] != emit_id) begin
                    stable_ok = 1'b0;
                end
                if (low_left > 0) begin
                    sr[sel] = 1'b0;
                    low_left--;
                end else begin
                    sr[sel] = 1'b1;
                end
            end else begin
                in_emit = 1'b0;
                sr[sel] = 1'b1;
            end
            if (sd[sel]) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        ss[sel] = 1'b0;
        exp_done = 13 + exp_ids.size() * (1 + lowc);
        check("done_cycle", done_cyc, exp_done);
        check("spike_n", got.size(), exp_ids.size());
        for (int i = 0; i < got.size() && i < exp_ids.size(); i++)
            check("spike_id", got[i], exp_ids[i]);
        check("id_stable", int'(stable_ok), 1);
        check("spike_count", int'(cnt[sel]), mcnt[sel]);
        for (int i = 0; i < 4; i++)
            check("membrane", get_v(sel, i), mv[sel][i]);
        @(negedge clk);
        check("done_pulse", int'(sd[sel]), 0);
        @(negedge clk);
        check("idle_after", int'(busy[sel]), 0);
    endtask

    typedef struct packed {
        logic            sel;
        logic [3:0][7:0] cur;
        logic [3:0]      lowc;
        logic            poke;
        logic [3:0]      mask;
        logic [1:0]      chk_n;
        logic [7:0]      chk_v;
        logic [7:0]      done;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int dc;
        int err;
        logic [3:0] gm;
        bit bad;

        tbl[0] = '{1'b0, mkcur(0, 0, 0, 0),   4'd0, 1'b0, 4'b0000, 2'd0, 8'd0,   8'd13};
        tbl[1] = '{1'b0, mkcur(60, 0, 0, 0),  4'd0, 1'b0, 4'b0000, 2'd0, 8'd60,  8'd13};
        tbl[2] = '{1'b0, mkcur(60, 0, 0, 0),  4'd0, 1'b0, 4'b0001, 2'd0, 8'd0,   8'd14};
        tbl[3] = '{1'b0, mkcur(60, 0, 0, 0),  4'd0, 1'b0, 4'b0000, 2'd0, 8'd0,   8'd13};
        tbl[4] = '{1'b0, mkcur(60, 0, 0, 0),  4'd0, 1'b0, 4'b0000, 2'd0, 8'd0,   8'd13};
        tbl[5] = '{1'b0, mkcur(60, 0, 0, 0),  4'd0, 1'b0, 4'b0000, 2'd0, 8'd60,  8'd13};
        tbl[6] = '{1'b0, mkcur(60, 0, 0, 0),  4'd5, 1'b1, 4'b0001, 2'd0, 8'd0,   8'd19};
        tbl[7] = '{1'b1, mkcur(0, 200, 0, 0), 4'd0, 1'b0, 4'b0000, 2'd1, 8'd200, 8'd13};
        tbl[8] = '{1'b1, mkcur(0, 200, 0, 0), 4'd0, 1'b0, 4'b0010, 2'd1, 8'd0,   8'd14};

        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            ss[s] = 1'b0; ic[s] = 8'd0; sr[s] = 1'b1;
        end
        model_reset();
        #1;
        check_zero(0);
        check_zero(1);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy[0] || sv[0] || sd[0] || cnt[0] != 16'd0) bad = 1'b1;
        end
        check("quiet_after_reset", int'(bad), 0);

        for (int k = 0; k < 9; k++) begin
            run_step(int'(tbl[k].sel), tbl[k].cur, int'(tbl[k].lowc), tbl[k].poke, dc, gm);
            check("tbl_done", dc, int'(tbl[k].done));
            check("tbl_mask", int'(gm), int'(tbl[k].mask));
            check("tbl_v", get_v(int'(tbl[k].sel), int'(tbl[k].chk_n)), int'(tbl[k].chk_v));
        end

        for (int k = 0; k < 40; k++) begin
            logic [3:0][7:0] rc;
            for (int i = 0; i < 4; i++) rc[i] = 8'($urandom_range(0, 90));
            run_step(0, rc, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), dc, gm);
        end

        // Abort during a stalled spike: outputs drop immediately, nothing completes.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run_step(0, mkcur(0, 255, 0, 0), 0, 1'b0, dc, gm);
        check("pre_abort_count", int'(cnt[0]), 1);
        @(negedge clk); ss[0] = 1'b1;
        @(negedge clk); ss[0] = 1'b0;
        sr[0] = 1'b0;
        ic[0] = 8'd255;
        for (int k = 0; k < 20; k++) begin
            if (sv[0]) break;
            @(negedge clk);
        end
        check("emit_reached", int'(sv[0]), 1);
        check("emit_id", int'(sid[0]), 0);
        #2 reset = 1'b1;
        #1;
        check_zero(0);
        for (int i = 0; i < 4; i++) check("abort_v", get_v(0, i), 0);
        @(negedge clk);
        reset = 1'b0;
        sr[0] = 1'b1;
        ic[0] = 8'd0;
        err = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sd[0] || busy[0] || cnt[0] != 16'd0) err++;
        end
        check("no_done_after_abort", err, 0);
        model_reset();
        run_step(0, mkcur(0, 0, 0, 0), 0, 1'b0, dc, gm);
        run_step(1, mkcur(0, 200, 0, 0), 0, 1'b0, dc, gm);
        check("dut2_v1_after_reset", get_v(1, 1), 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
